// File: rtl/mem_stage.sv
// Memory access stage: ALU results pass straight through, loads/stores run a
// registered request/ack handshake with upstream stall. Optional: LOAD_BYTE_EN.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        is_byte_in,
  input  logic        is_write_in,
  input  logic [3:0]  register_d_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] new_register_data_out,
  output logic        is_write_out,
  output logic [3:0]  register_d_out,
  output logic        stall_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] load_data;
  logic        mem_op;
  logic        issue;
  logic        capture;

  assign mem_op  = valid_in & (is_load_in | is_store_in);
  assign issue   = (state == IDLE) & mem_op;
  assign capture = (state == WAIT) & mem_ack;

`ifdef LOAD_BYTE_EN
  logic [1:0] byte_sel;
  logic       byte_op;

  function automatic logic [31:0] extract_byte(input logic [31:0] word,
                                               input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {24'h000000, b};
  endfunction

  // Byte lane and size are latched with the request so the response does not
  // depend on upstream inputs held during the stall.
  always_ff @(posedge clk) begin
    if (issue) begin
      byte_sel <= alu_result_in[1:0];
      byte_op  <= is_byte_in & ~is_store_in;
    end
  end

  function automatic logic [31:0] load_value(input logic [31:0] word);
    return byte_op ? extract_byte(word, byte_sel) : word;
  endfunction
`else
  logic unused_byte;
  assign unused_byte = is_byte_in;

  function automatic logic [31:0] load_value(input logic [31:0] word);
    return word;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op)  state_nxt = WAIT;
      WAIT:    if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers: loaded on issue, held through WAIT, request dropped on ack.
  // mem_we stays valid into RESP and identifies a store there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      load_data <= 32'h0;
    end else begin
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store_in;
        mem_addr  <= {alu_result_in[31:2], 2'b00};
        mem_wdata <= store_data_in;
      end else if (capture) begin
        mem_req   <= 1'b0;
      end
      if (capture) load_data <= load_value(mem_rdata);
    end
  end

  always_comb begin
    new_register_data_out = alu_result_in;
    is_write_out          = valid_in & is_write_in;
    register_d_out        = register_d_in;
    stall_out             = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_out    = 1'b1;
          is_write_out = 1'b0;
        end
      end
      WAIT: begin
        stall_out    = 1'b1;
        is_write_out = 1'b0;
      end
      RESP: begin
        if (mem_we) begin
          is_write_out = 1'b0;
        end else begin
          new_register_data_out = load_data;
          is_write_out          = is_write_in;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- valid_in  in  1  instruction present from execute stage.
- alu_result_in  in  32  ALU result; memory address for load/store.
- store_data_in  in  32  store write data.
- is_load_in  in  1  instruction is a load.
- is_store_in  in  1  instruction is a store.
- is_byte_in  in  1  byte-size load (used only with LOAD_BYTE_EN).
- is_write_in  in  1  instruction writes a register.
- register_d_in  in  4  destination register index.
- mem_ack  in  1  data memory completes request.
- mem_rdata  in  32  data memory read data, valid with mem_ack.
- mem_req  out  1  registered memory request.
- mem_we  out  1  registered write enable (1 = store).
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered store data.
- new_register_data_out  out  32  result to writeback register.
- is_write_out  out  1  write enable to writeback register.
- register_d_out  out  4  destination index to writeback register.
- stall_out  out  1  upstream holds all *_in stable while 1.
REQ-002 SHALL use one clock domain (clk); reset SHALL be asynchronous and active-high.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-004 In IDLE, valid_in=0 or neither load nor store: outputs combinational pass-through, new_register_data_out=alu_result_in, is_write_out=valid_in&is_write_in, register_d_out=register_d_in, stall_out=0; zero latency.
REQ-005 In IDLE, valid_in=1 with is_load_in or is_store_in: stall_out=1, is_write_out=0; next edge go WAIT, mem_req=1, mem_we=is_store_in, mem_addr={alu_result_in[31:2],2'b00}, mem_wdata=store_data_in.
REQ-006 In WAIT: mem_req and mem_addr/mem_we/mem_wdata held constant, stall_out=1, is_write_out=0; on mem_ack=1, next edge: mem_req=0, mem_rdata captured into internal load register, go RESP.
REQ-007 In RESP: stall_out=0; load -> new_register_data_out=load register, is_write_out=is_write_in; store -> is_write_out=0; register_d_out=register_d_in; next edge go IDLE unconditionally.
REQ-008 Minimum memory-op latency SHALL be 3 cycles (IDLE, WAIT with ack, RESP); each extra non-ack WAIT cycle adds 1.
REQ-009 mem_ack in IDLE or RESP SHALL be ignored.
REQ-010 is_load_in and is_store_in both 1 SHALL be treated as store.
REQ-011 Upstream input changes during stall_out=1 are a protocol violation; block uses values latched at IDLE->WAIT for memory outputs.

Reset
REQ-012 reset SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, load register=0, including mid-WAIT (request abandoned).
REQ-013 During reset, stall_out, is_write_out and new_register_data_out SHALL follow IDLE pass-through rules (REQ-004/005).

Configuration
REQ-014 Macro LOAD_BYTE_EN defined: load with is_byte_in=1 SHALL return byte mem_rdata[8*a+7:8*a], a=alu_result_in[1:0] latched at IDLE->WAIT, zero-extended to 32 bits.
REQ-015 LOAD_BYTE_EN undefined: is_byte_in port present but ignored; all loads return full 32-bit word.

Verification
REQ-016 ALU op valid_in=1, is_write_in=1, alu_result_in=0x0000_1234, register_d_in=5 -> same cycle data 0x1234, is_write_out=1, register_d_out=5, stall_out=0.
REQ-017 Load addr 0x0000_0104, ack after 2 WAIT cycles with mem_rdata=0xDEAD_BEEF -> mem_addr=0x104, stall_out=1 for 3 cycles, RESP data 0xDEADBEEF, is_write_out=1.
REQ-018 Store addr 0x20, data 0xCAFE_0001, ack first WAIT cycle -> mem_we=1, mem_wdata=0xCAFE0001, is_write_out=0 throughout, stall_out 1,1,0.
REQ-019 reset asserted in WAIT -> mem_req=0 same cycle, state IDLE, later ack ignored.
REQ-020 LOAD_BYTE_EN: byte load addr 0x2, mem_rdata=0x11AA_2233 -> data 0x0000_00AA; without macro -> 0x11AA2233.
